// File: rtl/sp_shift_bank.sv
// sp_shift_bank: sprite pixel engine for the PPU render path.
// Latches the secondary-OAM entries for the next scanline on a single load
// pulse, then emits one registered sprite pixel per pix_en using per-slot X
// down-counters and pattern shift registers.
//
// Ports:
//   clk, rst_n     dot clock, asynchronous active-low reset
//   load           latch all ld_* inputs; next pix_en is column 0
//   ld_active      per-slot valid
//   ld_x           per-slot X position, 8 bits each
//   ld_attr        per-slot attribute: [1:0] palette, [5] priority, [6] hflip
//   ld_lo, ld_hi   per-slot pattern bitplanes, SP_WIDTH bits each
//   ld_sp0         slot 0 carries OAM sprite 0
//   pix_en         advance one visible dot
//   clip_left      hide sprites in columns 0..7
//   sp_color_idx   {palette, color} of the winning pixel, 0 when transparent
//   sp_opaque      winning pixel color is nonzero
//   sp_prio        priority bit of the winner, 0 when transparent
//   sp0_opaque     sprite 0 is opaque and unclipped at this column
module sp_shift_bank #(
  parameter int NUM_SP   = 8,
  parameter int SP_WIDTH = 8,
  parameter int LINE_W   = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic [NUM_SP-1:0]            ld_active,
  input  logic [NUM_SP*8-1:0]          ld_x,
  input  logic [NUM_SP*8-1:0]          ld_attr,
  input  logic [NUM_SP*SP_WIDTH-1:0]   ld_lo,
  input  logic [NUM_SP*SP_WIDTH-1:0]   ld_hi,
  input  logic                         ld_sp0,
  input  logic                         pix_en,
  input  logic                         clip_left,
  output logic [3:0]                   sp_color_idx,
  output logic                         sp_opaque,
  output logic                         sp_prio,
  output logic                         sp0_opaque
);

  localparam int RW = $clog2(SP_WIDTH + 1);
  localparam logic [RW-1:0] REM_FULL = RW'(SP_WIDTH);
  localparam logic [RW-1:0] REM_ONE  = RW'(1);
  localparam logic [8:0]    COL_MAX  = 9'(LINE_W);

  logic [7:0]          xcnt     [NUM_SP];
  logic [RW-1:0]       rem      [NUM_SP];
  logic [SP_WIDTH-1:0] shift_lo [NUM_SP];
  logic [SP_WIDTH-1:0] shift_hi [NUM_SP];
  logic [1:0]          pal      [NUM_SP];
  logic                prio     [NUM_SP];
  logic [8:0]          col;
  logic                sp0_flag;

  logic [SP_WIDTH-1:0] ld_lo_f  [NUM_SP];
  logic [SP_WIDTH-1:0] ld_hi_f  [NUM_SP];
  logic [NUM_SP*4-1:0] attr_unused;

  logic [NUM_SP-1:0]   in_range;
  logic [1:0]          px       [NUM_SP];
  logic [1:0]          win_pix;
  logic [1:0]          win_pal;
  logic                win_prio;
  logic                sp0_hit;
  logic                clipped;

  // Horizontal flip is applied once at load so the shifter always emits MSB first.
  always_comb begin
    attr_unused = '0;
    for (int i = 0; i < NUM_SP; i++) begin
      ld_lo_f[i] = ld_lo[SP_WIDTH*i +: SP_WIDTH];
      ld_hi_f[i] = ld_hi[SP_WIDTH*i +: SP_WIDTH];
      if (ld_attr[8*i+6]) begin
        for (int b = 0; b < SP_WIDTH; b++) begin
          ld_lo_f[i][b] = ld_lo[SP_WIDTH*i + SP_WIDTH-1-b];
          ld_hi_f[i][b] = ld_hi[SP_WIDTH*i + SP_WIDTH-1-b];
        end
      end
      attr_unused[4*i +: 4] = {ld_attr[8*i+7], ld_attr[8*i+2 +: 3]};
    end
  end

  // Scan from the highest slot down so the lowest-index opaque slot is the
  // last to write and therefore wins; transparent slots never overwrite.
  always_comb begin
    win_pix  = 2'b00;
    win_pal  = 2'b00;
    win_prio = 1'b0;
    for (int i = 0; i < NUM_SP; i++) begin
      in_range[i] = (xcnt[i] == 8'd0) && (rem[i] != '0);
      px[i]       = {shift_hi[i][SP_WIDTH-1], shift_lo[i][SP_WIDTH-1]};
    end
    for (int i = NUM_SP-1; i >= 0; i--) begin
      if (in_range[i] && (px[i] != 2'b00)) begin
        win_pix  = px[i];
        win_pal  = pal[i];
        win_prio = prio[i];
      end
    end
    sp0_hit = sp0_flag && in_range[0] && (px[0] != 2'b00);
    clipped = (clip_left && (col < 9'd8)) || (col >= COL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SP; i++) begin
        xcnt[i]     <= '0;
        rem[i]      <= '0;
        shift_lo[i] <= '0;
        shift_hi[i] <= '0;
        pal[i]      <= '0;
        prio[i]     <= 1'b0;
      end
      col          <= '0;
      sp0_flag     <= 1'b0;
      sp_color_idx <= '0;
      sp_opaque    <= 1'b0;
      sp_prio      <= 1'b0;
      sp0_opaque   <= 1'b0;
    end else if (load) begin
      // Load takes precedence over pix_en; outputs hold this cycle.
      for (int i = 0; i < NUM_SP; i++) begin
        xcnt[i]     <= ld_x[8*i +: 8];
        rem[i]      <= ld_active[i] ? REM_FULL : '0;
        shift_lo[i] <= ld_lo_f[i];
        shift_hi[i] <= ld_hi_f[i];
        pal[i]      <= ld_attr[8*i +: 2];
        prio[i]     <= ld_attr[8*i+5];
      end
      col      <= '0;
      sp0_flag <= ld_sp0;
    end else if (pix_en) begin
      for (int i = 0; i < NUM_SP; i++) begin
        if (xcnt[i] != 8'd0) begin
          xcnt[i] <= xcnt[i] - 8'd1;
        end else if (rem[i] != '0) begin
          shift_lo[i] <= shift_lo[i] << 1;
          shift_hi[i] <= shift_hi[i] << 1;
          rem[i]      <= rem[i] - REM_ONE;
        end
      end
      if (col != COL_MAX) col <= col + 9'd1;
      sp_color_idx <= clipped ? 4'd0 : {win_pal, win_pix};
      sp_opaque    <= !clipped && (win_pix != 2'b00);
      sp_prio      <= !clipped && (win_pix != 2'b00) && win_prio;
      sp0_opaque   <= !clipped && sp0_hit;
    end
  end

endmodule

// File: tb/tb_sp_shift_bank.sv
module tb_sp_shift_bank;

  localparam int NSP = 8;
  localparam int SPW = 8;
  localparam int LW  = 256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 load;
  logic [NSP-1:0]       ld_active;
  logic [NSP*8-1:0]     ld_x;
  logic [NSP*8-1:0]     ld_attr;
  logic [NSP*SPW-1:0]   ld_lo;
  logic [NSP*SPW-1:0]   ld_hi;
  logic                 ld_sp0;
  logic                 pix_en;
  logic                 clip_left;
  logic [3:0]           sp_color_idx;
  logic                 sp_opaque;
  logic                 sp_prio;
  logic                 sp0_opaque;

  sp_shift_bank #(.NUM_SP(NSP), .SP_WIDTH(SPW), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .ld_active(ld_active), .ld_x(ld_x),
    .ld_attr(ld_attr), .ld_lo(ld_lo), .ld_hi(ld_hi), .ld_sp0(ld_sp0),
    .pix_en(pix_en), .clip_left(clip_left), .sp_color_idx(sp_color_idx),
    .sp_opaque(sp_opaque), .sp_prio(sp_prio), .sp0_opaque(sp0_opaque)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Reference model: the latched sprite list plus a column number.
  int         m_x    [NSP];
  logic [7:0] m_lo   [NSP];
  logic [7:0] m_hi   [NSP];
  bit         m_act  [NSP];
  bit         m_flip [NSP];
  bit [1:0]   m_pal  [NSP];
  bit         m_prio [NSP];
  bit         m_sp0;
  int         m_col;
  bit         m_emit;
  int         m_last;
  logic [3:0] e_idx;
  logic       e_opq, e_prio, e_sp0;

  int log_idx [LW+1];
  int log_opq [LW+1];
  int log_prio[LW+1];
  int log_sp0 [LW+1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSP; s++) m_act[s] = 0;
      m_sp0 = 0; m_col = 0; m_emit = 0;
      e_idx = 0; e_opq = 0; e_prio = 0; e_sp0 = 0;
    end else begin
      m_emit = 0;
      if (load) begin
        for (int s = 0; s < NSP; s++) begin
          m_act[s]  = ld_active[s];
          m_x[s]    = int'(ld_x[8*s +: 8]);
          m_lo[s]   = ld_lo[SPW*s +: SPW];
          m_hi[s]   = ld_hi[SPW*s +: SPW];
          m_flip[s] = ld_attr[8*s+6];
          m_pal[s]  = ld_attr[8*s +: 2];
          m_prio[s] = ld_attr[8*s+5];
        end
        m_sp0 = ld_sp0;
        m_col = 0;
      end else if (pix_en) begin
        bit found, hit0;
        int c, k, bp;
        bit [1:0] p;
        c = m_col; found = 0; hit0 = 0;
        e_idx = 0; e_opq = 0; e_prio = 0;
        for (int s = 0; s < NSP; s++) begin
          if (m_act[s] && c >= m_x[s] && c < m_x[s] + SPW) begin
            k  = c - m_x[s];
            bp = m_flip[s] ? k : SPW-1-k;
            p  = {m_hi[s][bp], m_lo[s][bp]};
            if (s == 0 && m_sp0 && p != 0) hit0 = 1;
            if (!found && p != 0) begin
              found = 1; e_idx = {m_pal[s], p}; e_opq = 1; e_prio = m_prio[s];
            end
          end
        end
        e_sp0 = hit0;
        if ((clip_left && c < 8) || c >= LW) begin
          e_idx = 0; e_opq = 0; e_prio = 0; e_sp0 = 0;
        end
        m_emit = 1; m_last = c;
        if (m_col < LW) m_col++;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (sp_color_idx !== e_idx || sp_opaque !== e_opq || sp_prio !== e_prio || sp0_opaque !== e_sp0) begin
      errs++;
      $display("FAIL cycle_cmp t=%0t col=%0d: got idx=%h opq=%b prio=%b sp0=%b required idx=%h opq=%b prio=%b sp0=%b",
               $time, m_last, sp_color_idx, sp_opaque, sp_prio, sp0_opaque, e_idx, e_opq, e_prio, e_sp0);
    end
    if (m_emit) begin
      log_idx[m_last]  = sp_color_idx;
      log_opq[m_last]  = sp_opaque;
      log_prio[m_last] = sp_prio;
      log_sp0[m_last]  = sp0_opaque;
    end
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_ld();
    ld_active = '0; ld_x = '0; ld_attr = '0; ld_lo = '0; ld_hi = '0; ld_sp0 = 0;
  endtask

  task automatic set_slot(int s, logic [7:0] x, logic [7:0] attr, logic [7:0] lo, logic [7:0] hi);
    ld_active[s] = 1'b1;
    ld_x[8*s +: 8] = x;
    ld_attr[8*s +: 8] = attr;
    ld_lo[SPW*s +: SPW] = lo;
    ld_hi[SPW*s +: SPW] = hi;
  endtask

  task automatic clear_log();
    for (int i = 0; i <= LW; i++) begin
      log_idx[i] = 0; log_opq[i] = 0; log_prio[i] = 0; log_sp0[i] = 0;
    end
  endtask

  task automatic do_load();
    clear_log();
    load = 1; cyc(); load = 0;
  endtask

  task automatic run(int n);
    pix_en = 1;
    repeat (n) cyc();
    pix_en = 0;
    cyc();
  endtask

  function automatic int count_opq(int lo, int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) n += log_opq[i];
    return n;
  endfunction

  initial begin
    rst_n = 0; load = 0; pix_en = 0; clip_left = 0;
    clear_ld();
    clear_log();
    repeat (3) cyc();
    chk("reset_idx", sp_color_idx, 0);
    chk("reset_flags", {sp_opaque, sp_prio, sp0_opaque}, 0);
    rst_n = 1;
    cyc();

    // Single sprite at x=10, palette 2, leftmost pixel only.
    clear_ld(); set_slot(0, 8'd10, 8'h02, 8'h80, 8'h00);
    do_load(); run(20);
    chk("single_col10", log_idx[10], 9);
    chk("single_count", count_opq(0, 19), 1);

    // Same with horizontal flip: pixel moves to column 17.
    clear_ld(); set_slot(0, 8'd10, 8'h42, 8'h80, 8'h00);
    do_load(); run(20);
    chk("flip_col17", log_idx[17], 9);
    chk("flip_count", count_opq(0, 19), 1);

    // Transparent slot 0 lets slot 1 through.
    clear_ld(); set_slot(0, 8'd0, 8'h00, 8'h00, 8'h00);
    set_slot(1, 8'd0, 8'h21, 8'hFF, 8'h00); ld_sp0 = 1;
    do_load(); run(10);
    for (int c = 0; c < 8; c++) begin
      chk("fall_idx", log_idx[c], 5);
      chk("fall_prio", log_prio[c], 1);
    end
    chk("fall_sp0", log_sp0[0] + log_sp0[3] + log_sp0[7], 0);

    // Overlap: slot 2 beats slot 5.
    clear_ld(); set_slot(2, 8'd40, 8'h03, 8'hFF, 8'hFF);
    set_slot(5, 8'd40, 8'h01, 8'hFF, 8'h00);
    do_load(); run(50);
    for (int c = 40; c < 48; c++) chk("overlap_idx", log_idx[c], 15);

    // Left clip with sprite 0.
    clear_ld(); set_slot(0, 8'd4, 8'h00, 8'hFF, 8'h00); ld_sp0 = 1; clip_left = 1;
    do_load(); run(14);
    chk("clip_hidden", count_opq(4, 7), 0);
    for (int c = 8; c < 12; c++) begin
      chk("clip_opq", log_opq[c], 1);
      chk("clip_sp0", log_sp0[c], 1);
    end
    clip_left = 0;

    // Sprite at x=255: single pixel, no wrap.
    clear_ld(); set_slot(0, 8'd255, 8'h00, 8'hFF, 8'hFF);
    do_load(); run(262);
    chk("edge_col255", log_idx[255], 3);
    chk("edge_count", count_opq(0, LW), 1);

    // load together with pix_en: outputs hold, no shift.
    clear_ld(); set_slot(0, 8'd0, 8'h02, 8'hFF, 8'h00);
    do_load();
    pix_en = 1; cyc(); cyc();
    chk("pre_load_idx", sp_color_idx, 9);
    clear_ld(); set_slot(0, 8'd0, 8'h01, 8'h80, 8'h00);
    load = 1; cyc(); load = 0;
    chk("load_pix_hold", sp_color_idx, 9);
    cyc();
    chk("load_no_shift", sp_color_idx, 5);
    cyc();
    chk("load_next_col", sp_color_idx, 0);
    pix_en = 0; cyc();

    // Asynchronous reset mid-line.
    clear_ld(); set_slot(0, 8'd0, 8'h02, 8'hFF, 8'hFF);
    do_load();
    pix_en = 1; cyc(); cyc();
    chk("pre_rst_idx", sp_color_idx, 11);
    #3 rst_n = 0;
    #1 chk("rst_immediate", {sp_color_idx, sp_opaque, sp_prio, sp0_opaque}, 0);
    cyc(); rst_n = 1;
    clear_log();
    run(20);
    chk("rst_silent", count_opq(0, 19), 0);

    // Randomized lines against the model.
    for (int line = 0; line < 40; line++) begin
      clear_ld();
      for (int s = 0; s < NSP; s++) begin
        if ($urandom_range(0, 1) == 1)
          set_slot(s, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 40)),
                   8'($urandom), 8'($urandom), 8'($urandom));
      end
      ld_sp0 = 1'($urandom_range(0, 1));
      pix_en = ($urandom_range(0, 3) == 0);
      load = 1; cyc(); load = 0;
      for (int t = 0; t < 270; t++) begin
        pix_en = ($urandom_range(0, 3) != 0);
        clip_left = ($urandom_range(0, 7) == 0) ? ~clip_left : clip_left;
        cyc();
      end
      pix_en = 0;
    end
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sp_shift_bank.md
# sp_shift_bank

Sequential, parametrised sprite pixel engine for the PPU render path. It takes the secondary-OAM entries for the next scanline in one load pulse. It then produces one sprite pixel per enabled dot using per-sprite X down-counters and pattern shift registers. Priority selection skips transparent pixels, so a lower-priority sprite shows through a transparent higher-priority one. It adds left-8-pixel clipping and a sprite-0 opacity flag for sprite-0-hit detection. It sits between the sprite evaluation/fetch logic and the background/sprite pixel mux.

## Interface
Parameters:
- NUM_SP, 8: number of secondary-OAM slots (1..16).
- SP_WIDTH, 8: pixels per sprite row; equals the pattern shift-register width.
- LINE_W, 256: visible dots per scanline; sets the column counter limit.

Ports:
- clk  in  1  PPU dot clock.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  one-cycle pulse that latches all ld_* inputs for the coming scanline.
- ld_active  in  NUM_SP  slot holds a valid sprite.
- ld_x  in  NUM_SP*8  X position; slot i is at bits [8i+7:8i].
- ld_attr  in  NUM_SP*8  OAM attribute byte: [1:0] palette, [5] priority, [6] horizontal flip. Other bits are ignored.
- ld_lo, ld_hi  in  NUM_SP*SP_WIDTH  pattern bitplanes, already vertically flipped upstream.
- ld_sp0  in  1  slot 0 holds OAM sprite 0.
- pix_en  in  1  advance one dot (visible column).
- clip_left  in  1  when high, suppress sprites in columns 0..7.
- sp_color_idx  out  4  {palette, color}; 0 when transparent.
- sp_opaque  out  1  winning pixel color is nonzero.
- sp_prio  out  1  attribute bit 5 of the winner; 0 when transparent.
- sp0_opaque  out  1  slot 0 is sprite 0 and its pixel at this column is opaque and not clipped. This is independent of which slot wins.

## Operation
- Per-slot state:
  - xcnt[7:0]
  - rem, with width clog2(SP_WIDTH+1)
  - shift_lo and shift_hi, each SP_WIDTH bits
  - pal[1:0], prio
- Shared state:
  - col, a 9-bit column counter
  - sp0_flag
- Load:
  - xcnt ← ld_x.
  - shift registers ← pattern, bit-reversed when attr[6] is set.
  - rem ← SP_WIDTH if the slot is active, else 0.
  - col ← 0.
  - sp0_flag ← ld_sp0.
- Per pix_en, for each slot:
  - If xcnt≠0, decrement xcnt; the slot is not in range.
  - Else if rem≠0, the slot is in range with pixel {shift_hi[MSB], shift_lo[MSB]}. Shift both registers left, filling with 0, and decrement rem.
  - Else the slot is idle.
- Winner: the lowest-index slot that is in range with a nonzero pixel. Transparent in-range slots fall through to higher indices.
- Clipping: if clip_left and col<8, or col≥LINE_W, the winner and sp0_opaque are forced transparent/0.
- col increments per pix_en and saturates at LINE_W.
- Column mapping: the pixel for column c (the c-th pix_en after load, 0-based) comes from a sprite with x≤c<x+SP_WIDTH, at pattern bit index c−x counted from the left (unflipped).
- No wrap: a sprite at x=255 shows only its first pixel. It never reappears at column 0.

## Timing
- Reset: all counters, shift registers and flags clear. All outputs are 0.
- Latency: outputs are registered. The result for a pix_en in cycle t is visible in cycle t+1.
- When pix_en is low, outputs and all state hold.
- load and pix_en together: load wins and no shift occurs. Outputs hold their previous value that cycle.
- A load mid-line discards the old line's state completely. The next pix_en is column 0.
- Reset asserted mid-line: outputs go to 0 immediately (asynchronous). Nothing is emitted until the next load.

## Test plan
- Single sprite:
  - Stimulus: slot0 x=10, lo=0x80, hi=0x00, pal=2, load, then 20 pix_en.
  - Response: sp_color_idx=4'b1001 only for the output of column 10. All other columns give 0.
- Horizontal flip:
  - Stimulus: same as above with attr[6]=1.
  - Response: opaque pixel at column 17 only.
- Transparent fall-through:
  - Stimulus: slot0 x=0 with lo=hi=0; slot1 x=0, lo=0xFF, pal=1, prio=1.
  - Response: columns 0..7 give sp_color_idx=4'b0101 and sp_prio=1. sp0_opaque=0 with ld_sp0=1.
- Overlap priority:
  - Stimulus: slot2 and slot5 both opaque at x=40.
  - Response: columns 40..47 show slot2's palette.
- Left clip and sprite-0 flag:
  - Stimulus: slot0 x=4, lo=0xFF, ld_sp0=1, clip_left=1.
  - Response: columns 4..7 give 0. Columns 8..11 are opaque with sp0_opaque=1.
- Edge and control cases:
  - Stimulus: x=255, then pix_en raised in the same cycle as load, then rst_n pulsed mid-line.
  - Response: only column 255 is opaque and nothing appears after it. No shift occurs in the load cycle. Outputs are 0 immediately on reset and stay 0 until the next load.
